seq_impl_checker: RTL and testbench

//  Synthesizable multi-channel checker for the implication property a |-> b ##DELAY c (or a |=> b ##DELAY c).

---
 rtl/seq_chk_pkg.sv | 19 +
 rtl/seq_impl_checker_if.sv | 20 ++
 rtl/seq_chk_lane.sv | 79 +++++++
 rtl/seq_impl_checker.sv | 52 +++++
 tb/tb_seq_impl_checker.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the sequence implication checker.
package seq_chk_pkg;

   localparam int MAX_DELAY = 16;

   typedef enum logic [1:0] {V_NONE, V_PASS, V_FAIL} verdict_t;

   // Adds 0..2 to a w-bit counter, clamping at 2^w-1 instead of wrapping.
   function automatic logic [31:0] sat_add(input logic [31:0] cnt,
                                           input logic [1:0]  inc,
                                           input int unsigned w);
      logic [32:0] w_max;
      logic [32:0] w_sum;
      w_max = (33'd1 << w) - 33'd1;
      w_sum = {1'b0, cnt} + {31'b0, inc};
      return (w_sum > w_max) ? w_max[31:0] : w_sum[31:0];
   endfunction

endpackage

// File: rtl/seq_impl_checker_if.sv
// Observation bus between the monitored design and the checker.
interface seq_impl_checker_if #(
   parameter int NCH   = 1,
   parameter int CNT_W = 8
) ();
   logic                 en_i;
   logic                 clr_i;
   logic [NCH-1:0]       a_i;
   logic [NCH-1:0]       b_i;
   logic [NCH-1:0]       c_i;
   logic [NCH-1:0]       pass_o;
   logic [NCH-1:0]       fail_o;
   logic [NCH-1:0]       err_o;
   logic [NCH*CNT_W-1:0] fail_cnt_o;

   modport slave  (input  en_i, clr_i, a_i, b_i, c_i,
                   output pass_o, fail_o, err_o, fail_cnt_o);
   modport master (output en_i, clr_i, a_i, b_i, c_i,
                   input  pass_o, fail_o, err_o, fail_cnt_o);
endinterface

// File: rtl/seq_chk_lane.sv
// One checker channel: optional a-stage, DELAY-deep pending pipe, verdicts,
// saturating fail counter and sticky error flag.
module seq_chk_lane
   import seq_chk_pkg::*;
#(
   parameter int DELAY  = 1,
   parameter int NONOVL = 0,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_a,
   input  logic             i_b,
   input  logic             i_c,
   output logic             o_pass,
   output logic             o_fail,
   output logic             o_err,
   output logic [CNT_W-1:0] o_cnt
);
   logic             w_start;
   logic             w_bs;
   logic             w_push;
   logic             w_bfail;
   logic [DELAY:0]   w_shift;
   logic [1:0]       w_ninc;
   logic [DELAY-1:0] r_pend;
   verdict_t         w_cverd;

   // Starts in a clear cycle are dropped, which also keeps the a-stage empty.
   assign w_start = i_en & i_a & ~i_clr;

   generate
      if (NONOVL != 0) begin : g_nonovl
         logic r_a_stg;
         always_ff @(posedge clk or posedge rst)
            if (rst) r_a_stg <= 1'b0;
            else     r_a_stg <= w_start;
         assign w_bs = r_a_stg;
      end else begin : g_ovl
         assign w_bs = w_start;
      end
   endgenerate

   assign w_push  = w_bs & i_b;
   assign w_bfail = w_bs & ~i_b;
   assign w_shift = {r_pend, w_push};

   always_comb begin
      w_cverd = V_NONE;
      if (r_pend[DELAY-1]) w_cverd = i_c ? V_PASS : V_FAIL;
   end

   // A new b-fail and an older c-fail can land together: count both.
   assign w_ninc = {1'b0, w_bfail} + {1'b0, (w_cverd == V_FAIL)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
         o_pass <= 1'b0;
         o_fail <= 1'b0;
         o_err  <= 1'b0;
         o_cnt  <= '0;
      end else if (i_clr) begin
         r_pend <= '0;
         o_pass <= 1'b0;
         o_fail <= 1'b0;
         o_err  <= 1'b0;
         o_cnt  <= '0;
      end else begin
         r_pend <= w_shift[DELAY-1:0];
         o_pass <= (w_cverd == V_PASS);
         o_fail <= |w_ninc;
         o_err  <= o_err | (|w_ninc);
         o_cnt  <= CNT_W'(sat_add(32'(o_cnt), w_ninc, CNT_W));
      end
   end
endmodule

// File: rtl/seq_impl_checker.sv
// Multi-channel checker for a |-> b ##DELAY c (NONOVL=0) or a |=> b ##DELAY c.
module seq_impl_checker
   import seq_chk_pkg::*;
#(
   parameter int NCH    = 1,
   parameter int DELAY  = 1,
   parameter int NONOVL = 0,
   parameter int CNT_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   seq_impl_checker_if.slave  bus
);
   logic [NCH-1:0]       w_pass;
   logic [NCH-1:0]       w_fail;
   logic [NCH-1:0]       w_err;
   logic [NCH*CNT_W-1:0] w_cnt;

   generate
      if (DELAY < 1 || DELAY > MAX_DELAY) begin : g_bad_delay
         $error("seq_impl_checker: DELAY must be in 1..%0d", MAX_DELAY);
      end
      if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
         $error("seq_impl_checker: CNT_W must be in 1..32");
      end

      for (genvar k = 0; k < NCH; k++) begin : g_lane
         seq_chk_lane #(
            .DELAY  (DELAY),
            .NONOVL (NONOVL),
            .CNT_W  (CNT_W)
         ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_en   (bus.en_i),
            .i_clr  (bus.clr_i),
            .i_a    (bus.a_i[k]),
            .i_b    (bus.b_i[k]),
            .i_c    (bus.c_i[k]),
            .o_pass (w_pass[k]),
            .o_fail (w_fail[k]),
            .o_err  (w_err[k]),
            .o_cnt  (w_cnt[k*CNT_W +: CNT_W])
         );
      end
   endgenerate

   assign bus.pass_o     = w_pass;
   assign bus.fail_o     = w_fail;
   assign bus.err_o      = w_err;
   assign bus.fail_cnt_o = w_cnt;
endmodule

// File: tb/tb_seq_impl_checker.sv
// Directed bench: table-driven vectors on a 2-channel |-> checker, plus
// hand sequences for |=>, counter saturation, clear and reset.
module tb_seq_impl_checker;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   seq_impl_checker_if #(.NCH(2), .CNT_W(8)) bus0 ();
   seq_impl_checker_if #(.NCH(1), .CNT_W(8)) bus1 ();
   seq_impl_checker_if #(.NCH(1), .CNT_W(2)) bus2 ();

   seq_impl_checker #(.NCH(2), .DELAY(2), .NONOVL(0), .CNT_W(8))
      u0 (.clk(clk), .rst(rst), .bus(bus0));
   seq_impl_checker #(.NCH(1), .DELAY(2), .NONOVL(1), .CNT_W(8))
      u1 (.clk(clk), .rst(rst), .bus(bus1));
   seq_impl_checker #(.NCH(1), .DELAY(2), .NONOVL(0), .CNT_W(2))
      u2 (.clk(clk), .rst(rst), .bus(bus2));

   typedef struct {
      logic       en, clr;
      logic [1:0] a, b, c;
      logic [1:0] p, f, e;
      logic [7:0] c0, c1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic en, logic clr, logic [1:0] a, logic [1:0] b,
                               logic [1:0] c, logic [1:0] p, logic [1:0] f,
                               logic [1:0] e, int c0, int c1);
      vec_t v;
      v.en = en; v.clr = clr; v.a = a; v.b = b; v.c = c;
      v.p = p; v.f = f; v.e = e; v.c0 = 8'(c0); v.c1 = 8'(c1);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus0.en_i = 1'b1; bus0.clr_i = 1'b0; bus0.a_i = '0; bus0.b_i = '0; bus0.c_i = '0;
      bus1.en_i = 1'b1; bus1.clr_i = 1'b0; bus1.a_i = '0; bus1.b_i = '0; bus1.c_i = '0;
      bus2.en_i = 1'b1; bus2.clr_i = 1'b0; bus2.a_i = '0; bus2.b_i = '0; bus2.c_i = '0;
   endtask

   initial begin
      idle_all();
      // en clr a b c | pass fail err cnt0 cnt1 (outputs after the edge)
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b00, 0,0)); // 0 start pass
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b01, 2'b01,2'b00,2'b00, 0,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0));
      tbl.push_back(mk(1,0,2'b01,2'b00,2'b00, 2'b00,2'b01,2'b01, 1,0)); // 4 b-fail
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01, 1,0));
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b01, 1,0)); // 6 back-to-back
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b01, 1,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b01,2'b01, 2,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b01, 2'b01,2'b00,2'b01, 2,0));
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b01, 2,0)); // 10 coincidence
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01, 2,0));
      tbl.push_back(mk(1,0,2'b01,2'b00,2'b00, 2'b00,2'b01,2'b01, 4,0));
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b01, 4,0)); // 13 pass+fail
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01, 4,0));
      tbl.push_back(mk(1,0,2'b01,2'b00,2'b01, 2'b01,2'b01,2'b01, 5,0));
      tbl.push_back(mk(1,0,2'b10,2'b10,2'b00, 2'b00,2'b00,2'b01, 5,0)); // 16 channel 1
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01, 5,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b10, 2'b10,2'b00,2'b01, 5,0));
      tbl.push_back(mk(1,0,2'b11,2'b01,2'b00, 2'b00,2'b10,2'b11, 5,1));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b11, 5,1));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b01, 2'b01,2'b00,2'b11, 5,1));
      tbl.push_back(mk(0,0,2'b01,2'b00,2'b00, 2'b00,2'b00,2'b11, 5,1)); // 22 en=0
      tbl.push_back(mk(0,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b11, 5,1));
      tbl.push_back(mk(0,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b11, 5,1));
      tbl.push_back(mk(0,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b11, 5,1));
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b11, 5,1)); // 26 en drops
      tbl.push_back(mk(0,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b11, 5,1));
      tbl.push_back(mk(0,0,2'b00,2'b00,2'b01, 2'b01,2'b00,2'b11, 5,1));
      tbl.push_back(mk(1,0,2'b01,2'b01,2'b00, 2'b00,2'b00,2'b11, 5,1)); // 29 clr
      tbl.push_back(mk(1,1,2'b01,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0));
      tbl.push_back(mk(1,0,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0));

      // Reset state
      tick();
      chk("rst_pass0", 32'(bus0.pass_o), 0);
      chk("rst_err0",  32'(bus0.err_o), 0);
      chk("rst_cnt0",  32'(bus0.fail_cnt_o), 0);
      chk("rst_err2",  32'(bus2.err_o), 0);
      @(negedge clk);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) begin
         bus0.en_i = tbl[i].en; bus0.clr_i = tbl[i].clr;
         bus0.a_i = tbl[i].a; bus0.b_i = tbl[i].b; bus0.c_i = tbl[i].c;
         tick();
         chk($sformatf("v%0d_pass", i), 32'(bus0.pass_o), 32'(tbl[i].p));
         chk($sformatf("v%0d_fail", i), 32'(bus0.fail_o), 32'(tbl[i].f));
         chk($sformatf("v%0d_err", i),  32'(bus0.err_o),  32'(tbl[i].e));
         chk($sformatf("v%0d_cnt0", i), 32'(bus0.fail_cnt_o[7:0]),  32'(tbl[i].c0));
         chk($sformatf("v%0d_cnt1", i), 32'(bus0.fail_cnt_o[15:8]), 32'(tbl[i].c1));
      end
      idle_all();

      // |=> pass: a at t, b at t+1, c at t+3 -> pass visible at t+4
      bus1.a_i = 1'b1; tick(); bus1.a_i = 1'b0;
      chk("nov_p_t1", 32'({bus1.pass_o, bus1.fail_o}), 0);
      bus1.b_i = 1'b1; tick(); bus1.b_i = 1'b0;
      chk("nov_p_t2", 32'({bus1.pass_o, bus1.fail_o}), 0);
      tick();
      chk("nov_p_t3", 32'({bus1.pass_o, bus1.fail_o}), 0);
      bus1.c_i = 1'b1; tick(); bus1.c_i = 1'b0;
      chk("nov_pass", 32'({bus1.pass_o, bus1.fail_o}), 32'b10);
      // |=> b-fail: visible at t+2
      bus1.a_i = 1'b1; tick(); bus1.a_i = 1'b0;
      chk("nov_f_t1", 32'(bus1.fail_o), 0);
      tick();
      chk("nov_bfail", 32'(bus1.fail_o), 1);
      chk("nov_cnt", 32'(bus1.fail_cnt_o), 1);
      // en drops after start; attempt still completes
      bus1.a_i = 1'b1; tick(); bus1.a_i = 1'b0; bus1.en_i = 1'b0;
      bus1.b_i = 1'b1; tick(); bus1.b_i = 1'b0;
      tick();
      bus1.c_i = 1'b1; tick(); bus1.c_i = 1'b0;
      chk("nov_en_drop", 32'(bus1.pass_o), 1);
      // a with en=0 starts nothing
      bus1.a_i = 1'b1; tick(); bus1.a_i = 1'b0;
      tick();
      chk("nov_en0", 32'(bus1.fail_o), 0);
      bus1.en_i = 1'b1;
      // start in a clear cycle is discarded
      bus1.a_i = 1'b1; bus1.clr_i = 1'b1; tick(); bus1.a_i = 1'b0; bus1.clr_i = 1'b0;
      chk("nov_clr_cnt", 32'(bus1.fail_cnt_o), 0);
      tick();
      chk("nov_clr_start", 32'(bus1.fail_o), 0);

      // Saturation with CNT_W=2
      for (int i = 0; i < 5; i++) begin
         bus2.a_i = 1'b1; tick();
         chk($sformatf("sat_%0d", i), 32'(bus2.fail_cnt_o), (i < 2) ? i + 1 : 3);
      end
      bus2.a_i = 1'b0; bus2.clr_i = 1'b1; tick(); bus2.clr_i = 1'b0;
      chk("clr_cnt", 32'(bus2.fail_cnt_o), 0);
      chk("clr_err", 32'(bus2.err_o), 0);
      bus2.a_i = 1'b1; tick(); tick();
      chk("sat_pre2", 32'(bus2.fail_cnt_o), 2);
      bus2.b_i = 1'b1; tick(); bus2.a_i = 1'b0; bus2.b_i = 1'b0; tick();
      bus2.a_i = 1'b1; tick(); bus2.a_i = 1'b0;
      chk("sat_plus2", 32'(bus2.fail_cnt_o), 3);
      chk("sat_fail", 32'(bus2.fail_o), 1);

      // Reset mid-attempt: no verdict, then checking resumes
      bus0.a_i = 2'b01; bus0.b_i = 2'b01; tick();
      bus0.a_i = '0; bus0.b_i = '0;
      rst = 1'b1; #2;
      chk("arst_cnt", 32'(bus0.fail_cnt_o), 0);
      rst = 1'b0;
      bus0.c_i = 2'b01; tick();
      chk("arst_v1", 32'({bus0.pass_o, bus0.fail_o}), 0);
      tick();
      chk("arst_v2", 32'({bus0.pass_o, bus0.fail_o}), 0);
      bus0.c_i = '0; bus0.a_i = 2'b01; bus0.b_i = 2'b01; tick();
      bus0.a_i = '0; bus0.b_i = '0; tick();
      bus0.c_i = 2'b01; tick(); bus0.c_i = '0;
      chk("arst_resume", 32'(bus0.pass_o), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
